// File: rtl/counter_sched_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and the
// constant that selects where each repetition after the first begins.
// Build option: define COUNTER_SCHED_CLR_EN to clear the counter before every run phase.
package counter_sched_pkg;

  // Sequencer states; ST_IDLE is the reset state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Entry point of every run phase after the first one.
`ifdef COUNTER_SCHED_CLR_EN
  localparam state_t NEXT_RUN_ST = ST_CLEAR;
`else
  localparam state_t NEXT_RUN_ST = ST_RUN;
`endif

endpackage

// File: rtl/counter_sched_if.sv
// Control/status bundle between a sequence requester and counter_sched.
// master: drives start/abort/run_len/pause_len/reps, observes value/cnt_en/busy/done.
// slave : the sequencer side (opposite directions).
interface counter_sched_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) ();

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] run_len;
  logic [WIDTH-1:0] pause_len;
  logic [REP_W-1:0] reps;
  logic [WIDTH-1:0] value;
  logic             cnt_en;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, run_len, pause_len, reps,
    input  value, cnt_en, busy, done
  );

  modport slave (
    input  start, abort, run_len, pause_len, reps,
    output value, cnt_en, busy, done
  );

endinterface

// File: rtl/counter_sched_counter.sv
// WIDTH-bit up counter with synchronous clear and count enable; wraps silently.
// Latency: value reflects clr/en one clock after they are sampled.
// Backpressure: none; clr has priority over en.
// Ports: clk, reset (async, active-high), clr, en, value.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_sched.sv
// Sequencer running a counter for reps run phases of run_len cycles separated by pause_len idle cycles.
// Latency: for a single repetition done is high in the cycle ending run_len+2 edges after the start edge.
// Backpressure: start is ignored while busy; abort returns to IDLE next cycle and freezes value.
// Ports: clk, reset (async, active-high), bus (counter_sched_if.slave).
// Build option: COUNTER_SCHED_CLR_EN - clear before every run phase instead of only the first.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  counter_sched_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] run_len_q, run_len_d;
  logic [WIDTH-1:0] pause_len_q, pause_len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [WIDTH-1:0] phase_q, phase_d;   // cycles elapsed in the current RUN/PAUSE
  logic [REP_W-1:0] rep_q, rep_d;       // run phases completed so far
  logic             cnt_en_q, cnt_en_d;

  logic             abort_act;
  logic             ctr_clr;
  logic             ctr_en;
  logic [WIDTH-1:0] ctr_value;

  assign abort_act = bus.abort && (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    pause_len_d = pause_len_q;
    reps_d      = reps_q;
    phase_d     = phase_q;
    rep_d       = rep_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          run_len_d   = bus.run_len;
          pause_len_d = bus.pause_len;
          reps_d      = bus.reps;
          phase_d     = '0;
          rep_d       = '0;
          // Nothing to count: finish straight away without touching value.
          if ((bus.run_len == '0) || (bus.reps == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end

      ST_CLEAR: begin
        phase_d = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (phase_q == (run_len_q - WIDTH'(1))) begin
          phase_d = '0;
          if (rep_q == (reps_q - REP_W'(1))) begin
            state_d = ST_DONE;
          end else begin
            rep_d   = rep_q + REP_W'(1);
            state_d = (pause_len_q == '0) ? NEXT_RUN_ST : ST_PAUSE;
          end
        end else begin
          phase_d = phase_q + WIDTH'(1);
        end
      end

      ST_PAUSE: begin
        if (phase_q == (pause_len_q - WIDTH'(1))) begin
          phase_d = '0;
          state_d = NEXT_RUN_ST;
        end else begin
          phase_d = phase_q + WIDTH'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition, including the one into DONE.
    if (abort_act) begin
      state_d = ST_IDLE;
    end

    // Registered enable: high exactly while the FSM sits in RUN.
    cnt_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_len_q   <= '0;
      pause_len_q <= '0;
      reps_q      <= '0;
      phase_q     <= '0;
      rep_q       <= '0;
      cnt_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      pause_len_q <= pause_len_d;
      reps_q      <= reps_d;
      phase_q     <= phase_d;
      rep_q       <= rep_d;
      cnt_en_q    <= cnt_en_d;
    end
  end

  // Abort takes effect in the cycle it is seen, so the counter is frozen at
  // the value it showed when abort arrived.
  assign ctr_clr = (state_q == ST_CLEAR) && !bus.abort;
  assign ctr_en  = cnt_en_q && !bus.abort;

  counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .value (ctr_value)
  );

  assign bus.value  = ctr_value;
  assign bus.cnt_en = cnt_en_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: WIDTH, default 8, width of the counter value and the run/pause lengths.
REQ-002 Parameter: REP_W, default 4, width of the repetition count.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 Port: abort  input  1  synchronous abort of an active sequence.
REQ-007 Port: run_len  input  WIDTH  number of enabled cycles per run phase.
REQ-008 Port: pause_len  input  WIDTH  number of idle cycles between run phases.
REQ-009 Port: reps  input  REP_W  number of run phases per sequence.
REQ-010 Port: value  output  WIDTH  current counter value.
REQ-011 Port: cnt_en  output  1  registered enable driven to the counter.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse at sequence end.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, RUN, PAUSE and DONE, with IDLE as the reset state.
REQ-015 In IDLE with start=1, the block SHALL latch run_len, pause_len and reps, then go to CLEAR; if run_len==0 or reps==0, it SHALL go directly to DONE instead.
REQ-016 CLEAR SHALL last one cycle, SHALL synchronously zero the counter, and SHALL then go to RUN.
REQ-017 RUN SHALL hold cnt_en=1 for exactly the latched run_len cycles, so value increments by run_len modulo 2^WIDTH.
REQ-018 At the end of RUN, the block SHALL go to DONE if this was the last repetition; otherwise it SHALL go to PAUSE, or to the next run entry if pause_len==0.
REQ-019 PAUSE SHALL hold cnt_en=0 for exactly pause_len cycles while value is held, then go to the next run entry.
REQ-020 The next run entry SHALL be CLEAR when the configuration macro is defined, and RUN otherwise.
REQ-021 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-022 start while busy SHALL be ignored, and the latched parameters SHALL be unaffected by input changes mid-sequence.
REQ-023 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with cnt_en=0, no done pulse, and value held.
REQ-024 If abort and the last RUN cycle coincide, abort SHALL win and done SHALL NOT pulse.
REQ-025 value SHALL wrap from 2^WIDTH-1 to 0 and SHALL raise no flag on wrap.
REQ-026 Latency: for reps=1, done SHALL pulse run_len+2 cycles after the start-sampling edge.

Reset
REQ-027 While reset is high, the block SHALL asynchronously force state=IDLE, value=0, cnt_en=0, busy=0, done=0 and all latched parameters to 0.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.

Configuration
REQ-029 With COUNTER_SCHED_CLR_EN defined, every run phase SHALL be preceded by CLEAR, so value restarts from 0 each repetition.
REQ-030 Without COUNTER_SCHED_CLR_EN, only the first run SHALL be preceded by CLEAR, so value accumulates across repetitions.

Structure
REQ-031 The state encoding typedef and the state constants SHALL live in a shared package, counter_sched_pkg.
REQ-032 One sub-module, counter (WIDTH-bit, with clear and enable), SHALL be instantiated for the datapath; the sequencing and phase/repetition counters SHALL stay in counter_sched.

Verification
REQ-033 run_len=5, reps=1, start pulsed -> value=5, done pulses 7 cycles after the start edge, busy high for the 6 cycles in between.
REQ-034 run_len=4, pause_len=3, reps=3, macro defined -> value reaches 4 three times, is cleared to 0 before each run, and done pulses once.
REQ-035 Same stimulus as REQ-034 with the macro undefined -> value ends at 12, and cnt_en is low for exactly 3 cycles in each of the 2 pauses.
REQ-036 run_len=0 or reps=0 -> done pulses 1 cycle after start, and cnt_en never rises.
REQ-037 abort asserted in the third RUN cycle -> IDLE next cycle, value held at 2, no done pulse.
REQ-038 run_len=255, then start again with the macro undefined -> value wraps 255->0 and continues; reset asserted mid-PAUSE -> all outputs 0 immediately.
